// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters advanced by a pixel-clock
// enable, with sync, data-enable, position and start-of-line/frame outputs all registered.
module video_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int COUNT_BITS = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [COUNT_BITS-1:0] x,
    output logic [COUNT_BITS-1:0] y,
    output logic                  line_start,
    output logic                  frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COUNT_BITS-1:0] C_ZERO    = {COUNT_BITS{1'b0}};
    localparam logic [COUNT_BITS-1:0] C_ONE     = {{(COUNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [COUNT_BITS-1:0] H_LAST    = COUNT_BITS'(H_TOTAL - 1);
    localparam logic [COUNT_BITS-1:0] V_LAST    = COUNT_BITS'(V_TOTAL - 1);
    localparam logic [COUNT_BITS-1:0] H_ACT     = COUNT_BITS'(H_ACTIVE);
    localparam logic [COUNT_BITS-1:0] V_ACT     = COUNT_BITS'(V_ACTIVE);
    localparam logic [COUNT_BITS-1:0] H_SYNC_LO = COUNT_BITS'(H_ACTIVE + H_FP);
    localparam logic [COUNT_BITS-1:0] H_SYNC_HI = COUNT_BITS'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COUNT_BITS-1:0] V_SYNC_LO = COUNT_BITS'(V_ACTIVE + V_FP);
    localparam logic [COUNT_BITS-1:0] V_SYNC_HI = COUNT_BITS'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    logic [COUNT_BITS-1:0] r_h;
    logic [COUNT_BITS-1:0] r_v;
    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_de;
    logic [COUNT_BITS-1:0] r_x;
    logic [COUNT_BITS-1:0] r_y;
    logic                  r_line_start;
    logic                  r_frame_start;

    logic w_h_last;
    logic w_v_last;
    logic w_h_active;
    logic w_v_active;
    logic w_h_in_sync;
    logic w_v_in_sync;

    assign w_h_last    = (r_h == H_LAST);
    assign w_v_last    = (r_v == V_LAST);
    assign w_h_active  = (r_h < H_ACT);
    assign w_v_active  = (r_v < V_ACT);
    assign w_h_in_sync = (r_h >= H_SYNC_LO) && (r_h < H_SYNC_HI);
    assign w_v_in_sync = (r_v >= V_SYNC_LO) && (r_v < V_SYNC_HI);

    // Counter advance and output registration; outputs describe the position the counters held before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h           <= C_ZERO;
            r_v           <= C_ZERO;
            r_hsync       <= ~SYNC_ON;
            r_vsync       <= ~SYNC_ON;
            r_de          <= 1'b0;
            r_x           <= C_ZERO;
            r_y           <= C_ZERO;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_hsync       <= w_h_in_sync ? SYNC_ON : ~SYNC_ON;
            r_vsync       <= w_v_in_sync ? SYNC_ON : ~SYNC_ON;
            r_de          <= w_h_active && w_v_active;
            r_x           <= r_h;
            r_y           <= r_v;
            r_line_start  <= (r_h == C_ZERO);
            r_frame_start <= (r_h == C_ZERO) && (r_v == C_ZERO);
            if (w_h_last) begin
                r_h <= C_ZERO;
                r_v <= w_v_last ? C_ZERO : (r_v + C_ONE);
            end else begin
                r_h <= r_h + C_ONE;
                r_v <= r_v;
            end
        end else begin
            // Pulses mark enabled edges only, so they drop while the enable is low.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboarded bench for video_timing_gen: one default-timing instance and one
// tiny-timing, active-high-sync instance, each compared cycle by cycle.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, en_a, reset_b, en_b;
    logic        hs_a, vs_a, de_a, ls_a, fs_a;
    logic        hs_b, vs_b, de_b, ls_b, fs_b;
    logic [11:0] x_a, y_a, x_b, y_b;

    video_timing_gen u_dut_a (
        .clk(clk), .reset(reset_a), .en(en_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .COUNT_BITS(12)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .en(en_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    // Output vector layout: {hsync, vsync, de, line_start, frame_start, x[11:0], y[11:0]}
    int          n_checks = 0;
    int          n_errors = 0;
    logic [28:0] sb_q[$];
    int          pos_cnt[2];
    logic [28:0] last_exp[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [28:0] idle_out(input int d);
        logic pol;
        pol = (d == 0) ? 1'b0 : 1'b1;
        return {~pol, ~pol, 27'd0};
    endfunction

    // Expected outputs for the n-th enabled edge since reset, derived from the pixel index.
    function automatic logic [28:0] model_out(input int d, input int n);
        int ha, hf, hs, hb, va, vf, vs, vb, ht, vt, px, py;
        logic pol, hsv, vsv, dev;
        if (d == 0) begin
            ha = 640; hf = 16; hs = 96; hb = 48; va = 480; vf = 10; vs = 2; vb = 33; pol = 1'b0;
        end else begin
            ha = 4; hf = 1; hs = 1; hb = 1; va = 2; vf = 1; vs = 1; vb = 1; pol = 1'b1;
        end
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        px  = n % ht;
        py  = (n / ht) % vt;
        dev = (px < ha) && (py < va);
        hsv = (px >= ha + hf && px < ha + hf + hs) ? pol : ~pol;
        vsv = (py >= va + vf && py < va + vf + vs) ? pol : ~pol;
        return {hsv, vsv, dev, (px == 0), (px == 0 && py == 0), 12'(px), 12'(py)};
    endfunction

    // Drive one clock of stimulus, push its expectation, then pop and compare after the edge.
    task automatic step(input int d, input logic rst, input logic e, output logic [28:0] obs);
        logic [28:0] exp_v;
        if (d == 0) begin
            reset_a = rst; en_a = e;
        end else begin
            reset_b = rst; en_b = e;
        end
        if (rst) begin
            exp_v      = idle_out(d);
            pos_cnt[d] = 0;
        end else if (e) begin
            exp_v      = model_out(d, pos_cnt[d]);
            pos_cnt[d] = pos_cnt[d] + 1;
        end else begin
            exp_v        = last_exp[d];
            exp_v[25:24] = 2'b00;
        end
        last_exp[d] = exp_v;
        sb_q.push_back(exp_v);
        @(posedge clk);
        #1;
        if (d == 0) obs = {hs_a, vs_a, de_a, ls_a, fs_a, x_a, y_a};
        else        obs = {hs_b, vs_b, de_b, ls_b, fs_b, x_b, y_b};
        chk((d == 0) ? "sb_a" : "sb_b", 32'(obs), 32'(sb_q.pop_front()));
    endtask

    initial begin
        logic [28:0] o;
        int de_hi, de_first_lo, hs_lo, hs_first, hs_last, ls_prev, ls_period;
        int fs_prev, fs_period;
        logic e;

        reset_a = 1'b1; en_a = 1'b0; reset_b = 1'b1; en_b = 1'b0;
        pos_cnt[0] = 0; pos_cnt[1] = 0;
        last_exp[0] = idle_out(0); last_exp[1] = idle_out(1);

        // Default instance: reset holds regardless of enable.
        step(0, 1'b1, 1'b1, o);
        step(0, 1'b1, 1'b0, o);
        chk("rst_a", 32'(o), 32'({2'b11, 27'd0}));

        de_hi = 0; de_first_lo = -1; hs_lo = 0; hs_first = -1; hs_last = -1;
        ls_prev = -1; ls_period = -1;
        for (int i = 0; i <= 1900; i++) begin
            step(0, 1'b0, 1'b1, o);
            if (i == 0) chk("first_pix", 32'({o[26:24], o[23:0]}), 32'({3'b111, 24'd0}));
            if (i < 800) begin
                if (o[26]) de_hi++;
                else if (de_first_lo < 0) de_first_lo = i;
                if (!o[28]) begin
                    hs_lo++;
                    if (hs_first < 0) hs_first = int'(o[23:12]);
                    hs_last = int'(o[23:12]);
                end
            end
            if (o[25]) begin
                if (ls_prev >= 0 && ls_period < 0) ls_period = i - ls_prev;
                ls_prev = i;
            end
        end
        chk("de_high", 32'(de_hi), 32'd640);
        chk("de_low_at", 32'(de_first_lo), 32'd640);
        chk("line_period", 32'(ls_period), 32'd800);
        chk("hs_width", 32'(hs_lo), 32'd96);
        chk("hs_first_x", 32'(hs_first), 32'd656);
        chk("hs_last_x", 32'(hs_last), 32'd751);
        chk("pos_300_2", 32'(o[23:0]), 32'({12'd300, 12'd2}));

        // Mid-frame reset, then restart from the origin.
        step(0, 1'b1, 1'b1, o);
        chk("mid_rst", 32'(o), 32'({2'b11, 27'd0}));
        step(0, 1'b1, 1'b0, o);
        step(0, 1'b0, 1'b1, o);
        chk("restart", 32'({o[26:24], o[23:0]}), 32'({3'b111, 24'd0}));

        // Enable toggling: 1,0,1,0 then a random pattern; no pulses in disabled cycles.
        for (int i = 0; i < 80; i++) begin
            e = (i < 20) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
            step(0, 1'b0, e, o);
            if (!e) chk("pulse_en0", 32'(o[25:24]), 32'd0);
        end

        // Small instance with active-high sync.
        step(1, 1'b1, 1'b1, o);
        step(1, 1'b1, 1'b1, o);
        chk("rst_b", 32'(o), 32'd0);
        fs_prev = -1; fs_period = -1;
        for (int i = 0; i < 80; i++) begin
            step(1, 1'b0, 1'b1, o);
            if (i < 7) chk("xseq", 32'(o[23:12]), 32'(i));
            chk("hs_b_at5", 32'(o[28]), 32'(o[23:12] == 12'd5));
            chk("vs_b_at3", 32'(o[27]), 32'(o[11:0] == 12'd3));
            if (o[24]) begin
                if (fs_prev >= 0 && fs_period < 0) fs_period = i - fs_prev;
                fs_prev = i;
            end
        end
        chk("frame_period", 32'(fs_period), 32'd35);
        for (int i = 0; i < 60; i++) begin
            e = 1'($urandom_range(0, 1));
            step(1, 1'b0, e, o);
            if (!e) chk("pulse_en0_b", 32'(o[25:24]), 32'd0);
        end
        step(1, 1'b1, 1'b0, o);
        chk("mid_rst_b", 32'(o), 32'd0);
        step(1, 1'b0, 1'b1, o);
        chk("restart_b", 32'(o[24]), 32'd1);
        for (int i = 0; i < 20; i++) step(1, 1'b0, 1'b1, o);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
